// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared width codes, opcodes, FSM states and request legality check
// Contents: RV32I funct3 width codes, load/store opcodes, state_t, access_err()
package data_mem_responder_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    // Illegal width code or misaligned lane; the address range check lives in the top
    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic legal;
        legal = we ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return !legal || (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between an initiator and the data memory responder
// master: drives req_valid/req_we/req_funct3/req_addr/req_wdata/resp_ready
// slave : drives req_ready/resp_valid/resp_rdata/resp_err
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// mem_lane_align: combinational byte-lane extract/extend for loads and lane merge for stores
// Inputs : funct3, addr_lo (byte lane), mem_word (current stored word), wdata (right-aligned store data)
// Outputs: load_data (extended load result), store_word (mem_word with addressed lanes replaced)
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  be;
    logic [31:0] wrep;
    assign byte_sel = 8'(mem_word >> {addr_lo, 3'b000});
    assign half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    always_comb begin
        load_data = funct3 == F3_B  ? {{24{byte_sel[7]}}, byte_sel} :
                    funct3 == F3_BU ? {24'd0, byte_sel} :
                    funct3 == F3_H  ? {{16{half_sel[15]}}, half_sel} :
                    funct3 == F3_HU ? {16'd0, half_sel} :
                    funct3 == F3_W  ? mem_word : 32'd0;
        be   = funct3 == F3_B ? 4'b0001 << addr_lo :
               funct3 == F3_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
               funct3 == F3_W ? 4'b1111 : 4'b0000;
        // Replicate store data so every enabled lane sees its own low bits
        wrep = funct3 == F3_B ? {4{wdata[7:0]}} :
               funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
        store_word = mem_word;
        for (int i = 0; i < 4; i++)
            if (be[i]) store_word[8*i +: 8] = wrep[8*i +: 8];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering load/store requests after LATENCY wait cycles
// Ports: clk, rst (async active-high), bus (slave side of data_mem_responder_if)
// Params: DEPTH_WORDS (power of two, >=4), LATENCY (>=1 wait cycles per legal access)
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic clk,
    input logic rst,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [2:0]     f3_q, f3_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [1:0]     lo_q, lo_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [31:0]    mem_q [DEPTH_WORDS];
    logic [31:0]    load_data, store_word;
    logic           last, bad, mem_we;
    mem_lane_align u_align (
        .funct3     (f3_q),
        .addr_lo    (lo_q),
        .mem_word   (mem_q[idx_q]),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );
    assign bus.req_ready  = state_q == IDLE && !rst;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign last   = cnt_q == CW'(LATENCY - 1);
    assign bad    = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) ||
                    bus.req_addr >= 32'(4 * DEPTH_WORDS);
    // The access happens on the final WAIT edge; reset drops state to IDLE first, aborting it
    assign mem_we = state_q == WAIT && last && we_q && !rst;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.req_valid && bus.req_ready) begin
                we_d    = bus.req_we;
                f3_d    = bus.req_funct3;
                idx_d   = bus.req_addr[AW+1:2];
                lo_d    = bus.req_addr[1:0];
                wdata_d = bus.req_wdata;
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = bad;
                state_d = bad ? RESP : WAIT;
            end
            WAIT: if (last) begin
                rdata_d = we_q ? 32'd0 : load_data;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: if (bus.resp_ready) begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    // Storage is deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= store_word;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2)
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    data_mem_responder_if bus();
    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;

    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.resp_valid && lat < 20);
        checks++;
        if (!bus.resp_valid) begin
            errors++;
            $display("FAIL timeout addr=%h we=%b f3=%b: no resp_valid within %0d cycles", a, we, f3, lat);
        end
        rd = bus.resp_rdata;
        e  = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b expected all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b valid=%b expected ready=1 valid=0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        logic e;
        int lat;
        xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e, lat);
        checks++;
        if (rd !== 32'd0 || e !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL sw_10 got rdata=%h err=%b lat=%0d expected rdata=0 err=0 lat=2", rd, e, lat);
        end
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL lw_10 got rdata=%h err=%b lat=%0d expected rdata=deadbeef err=0 lat=2", rd, e, lat);
        end
    endtask

    task automatic test_extend;
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        logic [31:0] rd;
        logic e;
        int lat;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, f3[i], ad[i], 32'h0, rd, e, lat);
            checks++;
            if (rd !== exp[i] || e !== 1'b0 || lat !== 2) begin
                errors++;
                $display("FAIL extend f3=%b addr=%h got rdata=%h err=%b lat=%0d expected rdata=%h err=0 lat=2",
                         f3[i], ad[i], rd, e, lat, exp[i]);
            end
        end
    endtask

    task automatic test_partial_stores;
        logic [31:0] rd;
        logic e;
        int lat;
        xfer(1'b1, 3'b000, 32'h11, 32'h55, rd, e, lat);
        checks++;
        if (rd !== 32'd0 || e !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL sb_11 got rdata=%h err=%b lat=%0d expected rdata=0 err=0 lat=2", rd, e, lat);
        end
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEAD55EF || e !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_sb got rdata=%h err=%b expected rdata=dead55ef err=0", rd, e);
        end
        xfer(1'b1, 3'b010, 32'h30, 32'h11223344, rd, e, lat);
        xfer(1'b1, 3'b001, 32'h32, 32'h0000BEEF, rd, e, lat);
        xfer(1'b1, 3'b000, 32'h30, 32'hFFFFFF99, rd, e, lat);
        xfer(1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hBEEF3399 || e !== 1'b0) begin
            errors++;
            $display("FAIL lw_after_sh_sb got rdata=%h err=%b expected rdata=beef3399 err=0", rd, e);
        end
        xfer(1'b0, 3'b100, 32'h31, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h00000033 || e !== 1'b0) begin
            errors++;
            $display("FAIL lbu_31 got rdata=%h err=%b expected rdata=00000033 err=0", rd, e);
        end
    endtask

    task automatic test_errors;
        logic        we [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b011, 3'b110};
        logic [31:0] ad [6] = '{32'h12, 32'h01, 32'h10, 32'h400, 32'h10, 32'h0};
        logic [31:0] rd;
        logic e;
        int lat;
        xfer(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, rd, e, lat);
        for (int i = 0; i < 6; i++) begin
            xfer(we[i], f3[i], ad[i], 32'hFFFFFFFF, rd, e, lat);
            checks++;
            if (rd !== 32'd0 || e !== 1'b1 || lat !== 1) begin
                errors++;
                $display("FAIL err_case we=%b f3=%b addr=%h got rdata=%h err=%b lat=%0d expected rdata=0 err=1 lat=1",
                         we[i], f3[i], ad[i], rd, e, lat);
            end
        end
        xfer(1'b0, 3'b010, 32'h0, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
            errors++;
            $display("FAIL err_no_write_0 got rdata=%h err=%b expected rdata=cafef00d err=0", rd, e);
        end
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEAD55EF || e !== 1'b0) begin
            errors++;
            $display("FAIL err_no_write_10 got rdata=%h err=%b expected rdata=dead55ef err=0", rd, e);
        end
        xfer(1'b1, 3'b010, 32'h3FC, 32'h0BADCAFE, rd, e, lat);
        xfer(1'b0, 3'b010, 32'h3FC, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h0BADCAFE || e !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL last_word got rdata=%h err=%b lat=%0d expected rdata=0badcafe err=0 lat=2", rd, e, lat);
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEAD55EF || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d got valid=%b rdata=%h err=%b ready=%b expected valid=1 rdata=dead55ef err=0 ready=0",
                         i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
            end
            if (i < 5) @(posedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got valid=%b ready=%b expected valid=0 ready=1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd;
        logic e;
        int lat;
        xfer(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, rd, e, lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0 || dut.cnt_q !== '0) begin
            errors++;
            $display("FAIL rst_wait got ready=%b valid=%b rdata=%h err=%b cnt=%0d expected all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, dut.cnt_q);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hA5A5A5A5 || e !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_write got rdata=%h err=%b expected rdata=a5a5a5a5 err=0", rd, e);
        end
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h10;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp got valid=%b rdata=%h ready=%b expected valid=0 rdata=0 ready=0",
                     bus.resp_valid, bus.resp_rdata, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_extend();
        test_partial_stores();
        test_errors();
        test_hold();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
